// File: rtl/touch_pkg.sv
// touch_pkg: command bytes, screen size, sampler states and raw sample type
package touch_pkg;
   localparam logic [7:0] CMD_X  = 8'hD0;
   localparam logic [7:0] CMD_Y  = 8'h90;
   localparam logic [7:0] CMD_Z1 = 8'hB0;
   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   typedef enum logic [2:0] {IDLE, CMD, READ, GAP, SCALE} state_t;
   typedef logic [11:0] raw_t;
endpackage

// File: rtl/spi_xfer24.sv
// spi_xfer24: one mode-0 SPI transfer of 24 SCLK periods (8-bit command out, 16 bits in, 12-bit result)
module spi_xfer24
   import touch_pkg::*;
#(
   parameter int CLK_DIV = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] cmd,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic       cs_n,
   output logic       reading,
   output logic       done,
   output raw_t       result
);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   logic          active;
   logic [DW-1:0] div;
   logic [5:0]    half;
   logic [7:0]    tx;
   logic [14:0]   rx;
   assign reading = active && (half >= 6'd16);
   // even halves hold SCLK low and odd halves high; half 48 is the trailing low half before CS rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
         cs_n   <= 1'b1;
         sclk   <= 1'b0;
         mosi   <= 1'b0;
         div    <= '0;
         half   <= '0;
         tx     <= '0;
         rx     <= '0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         if (!active) begin
            if (start) begin
               active <= 1'b1;
               cs_n   <= 1'b0;
               mosi   <= cmd[7];
               tx     <= {cmd[6:0], 1'b0};
               div    <= '0;
               half   <= '0;
            end
         end else if (div != DIV_LAST) begin
            div <= div + 1'b1;
         end else begin
            div <= '0;
            if (half == 6'd48) begin
               active <= 1'b0;
               cs_n   <= 1'b1;
               done   <= 1'b1;
               result <= rx[14:3];
            end else begin
               half <= half + 6'd1;
               sclk <= ~half[0];
               if (!half[0]) begin
                  rx <= {rx[13:0], miso};
               end else begin
                  mosi <= tx[7];
                  tx   <= {tx[6:0], 1'b0};
               end
            end
         end
      end
   end
endmodule

// File: rtl/touch_sampler.sv
// touch_sampler: periodic XPT2046 X/Y/Z1 reads scaled to 320x240 screen coordinates with touch detect
module touch_sampler
   import touch_pkg::*;
#(
   parameter int          CLK_DIV       = 8,
   parameter int          SAMPLE_PERIOD = 100000,
   parameter logic [11:0] Z_THRESH      = 12'h040
) (
   input  logic       clk_in,
   input  logic       rst_in_n,
   input  logic       enable_in,
   input  logic       spi_miso_in,
   output logic       spi_sclk_out,
   output logic       spi_mosi_out,
   output logic       spi_cs_n_out,
   output logic [8:0] x_out,
   output logic [7:0] y_out,
   output logic       touch_out,
   output logic       valid_out,
   output logic       busy_out
);
   localparam int TW = $clog2(SAMPLE_PERIOD);
   localparam int GW = $clog2(CLK_DIV);
   state_t        state, state_nx;
   logic [TW-1:0] timer;
   logic [GW-1:0] gap;
   logic [1:0]    ch;
   raw_t          raw_x, raw_y, raw_z, result;
   logic          start, reading, done, wrap, gap_end, touched;
   logic [7:0]    cmd;
   assign wrap     = timer == TW'(SAMPLE_PERIOD - 1);
   assign gap_end  = gap == GW'(CLK_DIV - 2);
   assign touched  = raw_z >= Z_THRESH;
   assign busy_out = state != IDLE;
   spi_xfer24 #(.CLK_DIV(CLK_DIV)) u_xfer (
      .clk     (clk_in),
      .rst_n   (rst_in_n),
      .start   (start),
      .cmd     (cmd),
      .miso    (spi_miso_in),
      .sclk    (spi_sclk_out),
      .mosi    (spi_mosi_out),
      .cs_n    (spi_cs_n_out),
      .reading (reading),
      .done    (done),
      .result  (result)
   );
   // channel sequencing: GAP ends one cycle early so CS stays high exactly CLK_DIV cycles
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      cmd      = CMD_X;
      case (state)
         IDLE: if (wrap && enable_in) begin
            state_nx = CMD;
            start    = 1'b1;
         end
         CMD: if (reading) state_nx = READ;
         READ: if (done) state_nx = GAP;
         GAP: if (gap_end) begin
            state_nx = (ch == 2'd2) ? SCALE : CMD;
            start    = ch != 2'd2;
            cmd      = (ch == 2'd0) ? CMD_Y : CMD_Z1;
         end
         SCALE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // period timer, raw capture and scaled output registers
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state     <= IDLE;
         timer     <= '0;
         gap       <= '0;
         ch        <= '0;
         raw_x     <= '0;
         raw_y     <= '0;
         raw_z     <= '0;
         x_out     <= '0;
         y_out     <= '0;
         touch_out <= 1'b0;
         valid_out <= 1'b0;
      end else begin
         state     <= state_nx;
         timer     <= wrap ? '0 : timer + 1'b1;
         gap       <= (state == GAP) ? gap + 1'b1 : '0;
         valid_out <= state == SCALE;
         if (start) ch <= (state == IDLE) ? 2'd0 : ch + 2'd1;
         if (done) begin
            if (ch == 2'd0) raw_x <= result;
            if (ch == 2'd1) raw_y <= result;
            if (ch == 2'd2) raw_z <= result;
         end
         if (state == SCALE) begin
            touch_out <= touched;
            if (touched) begin
               x_out <= 9'((21'(raw_x) * 21'(SCREEN_W)) >> 12);
               y_out <= 8'((20'(raw_y) * 20'(SCREEN_H)) >> 12);
            end
         end
      end
   end
endmodule

// File: doc/touch_sampler.md
Name: touch_sampler

Overview:
- SPI master for the resistive touch controller (XPT2046/TSC2046 command set). Produces the screen-space touch coordinates that the touch-processing/palette logic consumes.
- Periodically reads the X, Y and Z1 channels, scales the raw 12-bit values to 320x240 screen space and flags a touch on pressure.
- Sits between the controller pins and the draw/palette path. Single clock domain.

Parameters:
- CLK_DIV, 8: clk_in cycles per SCLK half-period (>=2).
- SAMPLE_PERIOD, 100000: clk_in cycles between frame starts. Must exceed the frame length.
- Z_THRESH, 12'h040: Z1 raw value at or above which the panel counts as touched.

Ports:
- clk_in  input  1  system clock
- rst_in_n  input  1  asynchronous, active-low reset
- enable_in  input  1  allows new frames to start
- spi_miso_in  input  1  controller DOUT
- spi_sclk_out  output  1  SPI clock, idle low
- spi_mosi_out  output  1  controller DIN
- spi_cs_n_out  output  1  chip select, active low
- x_out  output  9  screen x, 0..319
- y_out  output  8  screen y, 0..239
- touch_out  output  1  1 = panel pressed in the last frame
- valid_out  output  1  one-cycle pulse when x_out/y_out/touch_out update
- busy_out  output  1  1 while a frame is in progress

Behaviour:
- Reset values: spi_sclk_out=0, spi_cs_n_out=1, spi_mosi_out=0, x_out=0, y_out=0, touch_out=0, valid_out=0, busy_out=0. All internal counters clear.
- Reset is asynchronous. Asserting it mid-transfer forces CS high and SCLK low on the same edge and abandons the frame.
- Period timer: free-running and wraps at SAMPLE_PERIOD-1. A frame starts on the wrap only if enable_in=1 and the FSM is in IDLE. A wrap with enable_in=0 is skipped.
- Frame: three channels in fixed order. Commands are X=8'hD0, Y=8'h90, Z1=8'hB0 (12-bit, differential, power-down between conversions).
- Per channel:
  - CS falls, then exactly 24 SCLK periods run, then CS rises for CLK_DIV cycles (GAP) before the next channel.
  - SCLK periods 1-8 shift the command out MSB first. Periods 9-24 shift in 16 bits.
  - Raw value = received bits [14:3]: drop the leading busy bit and the three trailing zeros.
- SPI timing (mode 0):
  - MOSI is valid CLK_DIV cycles before the first rising edge and changes only after falling edges.
  - MISO is sampled on the clk_in cycle where SCLK goes 0->1.
  - MOSI=0 during periods 9-24.
- FSM states: IDLE -> CMD (8 periods) -> READ (16 periods) -> GAP. After GAP, go to CMD for the next channel, or to SCALE after Z1. SCALE -> IDLE. busy_out=1 in every state except IDLE.
- SCALE, one cycle:
  - sx = raw_x*320 (21 bits); x_out <= sx[20:12].
  - sy = raw_y*240 (20 bits); y_out <= sy[19:12].
  - The result is never outside 0..319 / 0..239, so no clamping is needed.
- Touch handling:
  - touch_out <= (raw_z1 >= Z_THRESH).
  - If not touched, x_out/y_out hold their previous values and only touch_out updates.
  - valid_out pulses once per frame on the cycle after SCALE, whether or not the panel is touched.
- enable_in falling mid-frame does not abort the frame. It completes and valid_out still pulses.
- Frame latency: 3*(48*CLK_DIV + 2*CLK_DIV) + 2 cycles from start to valid_out, within ±2 cycles of edge alignment. The bench checks this.

Decomposition:
- Package touch_pkg holds:
  - command byte constants CMD_X/CMD_Y/CMD_Z1
  - SCREEN_W=320 and SCREEN_H=240
  - the state enum (IDLE, CMD, READ, GAP, SCALE)
  - the 12-bit raw typedef
- One sub-module, spi_xfer24:
  - performs one 24-period transfer given an 8-bit command
  - handles SCLK generation, CS and the shift registers
  - start/done handshake: start is accepted only while idle; done pulses one cycle with a 12-bit result
- touch_sampler keeps the period timer, channel sequencing, scaling and output registers.

Test Plan:
1. Controller model returns X=12'h800, Y=12'h800, Z1=12'h100 -> after valid_out: x_out=160, y_out=120, touch_out=1. Exactly 72 SCLK rising edges occurred and CS fell 3 times.
2. Model returns X=12'hFFF, Y=12'hFFF, Z1=12'hFFF -> x_out=319, y_out=239. Then X=0, Y=0 -> x_out=0, y_out=0.
3. Frame 1 touched at X=12'h400 (x=80); frame 2 Z1=12'h010 with Z_THRESH=12'h040 -> frame 2 gives touch_out=0, x_out stays 80, and valid_out still pulses.
4. Check MOSI against the model: bytes D0, 90, B0 shifted MSB first, stable around each rising SCLK edge, MOSI=0 during read periods.
5. Assert rst_in_n low in the middle of the Y channel -> CS=1 and SCLK=0 immediately, all outputs return to reset values, and the next frame starts cleanly from the X channel.
6. Hold enable_in=0 for 3 timer wraps -> CS stays high with no valid_out. Drop enable_in mid-frame -> that frame completes with one valid_out, then no further frames start.
